// File: rtl/ddr3_frame_pkg.sv
// Shared types and defaults for the DDR3 ping-pong frame reader.
package ddr3_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_CLEAR
    } state_t;

    localparam int DDR3_ADDR_W         = 26;
    localparam int DEFAULT_DATA_W      = 64;
    localparam int DEFAULT_BURST_LEN   = 16;
    localparam int DEFAULT_FRAME_WORDS = 153600;
    localparam int DEFAULT_FIFO_DEPTH  = 512;

    // Word counters must be able to hold FRAME_WORDS itself.
    function automatic int cnt_w(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/ddr3_frame_reader_credit.sv
// Issued/received word counters and the downstream FIFO space check for burst issue.
module ddr3_burst_credit
    import ddr3_frame_pkg::*;
#(
    parameter int BURST_LEN   = DEFAULT_BURST_LEN,
    parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             accept,
    input  logic                             recv,
    input  logic [$clog2(FIFO_DEPTH):0]      fifo_used,
    output logic [cnt_w(FRAME_WORDS)-1:0]    issued_words,
    output logic [cnt_w(FRAME_WORDS)-1:0]    recv_words,
    output logic                             credit_ok,
    output logic                             last_burst,
    output logic                             first_word,
    output logic                             last_word
);

    localparam int CNT_W = cnt_w(FRAME_WORDS);

    logic [31:0] need;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            issued_words <= '0;
            recv_words   <= '0;
        end else begin
            if (accept)
                issued_words <= issued_words + CNT_W'(BURST_LEN);
            if (recv)
                recv_words <= recv_words + CNT_W'(1);
        end
    end

    // Words in flight plus FIFO fill plus the next burst must fit in the FIFO.
    assign need = 32'(issued_words) - 32'(recv_words) + 32'(fifo_used) + 32'(BURST_LEN);
    assign credit_ok  = (need <= 32'(FIFO_DEPTH));
    assign last_burst = (issued_words == CNT_W'(FRAME_WORDS - BURST_LEN));
    assign first_word = (recv_words == '0);
    assign last_word  = (recv_words == CNT_W'(FRAME_WORDS - 1));

endmodule

// File: rtl/ddr3_frame_reader.sv
// Ping-pong frame fetcher: reads a full DDR3 buffer in bursts, streams it to the pixel FIFO, then releases it.
module ddr3_frame_reader
    import ddr3_frame_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int BURST_LEN   = DEFAULT_BURST_LEN,
    parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                         ddr3_clk,
    input  logic                         ddr3_reset,
    input  logic                         ddr3_rd_buffer0_empty,
    input  logic                         ddr3_rd_buffer1_empty,
    input  logic [DDR3_ADDR_W-1:0]       ddr3_buffer0_offset,
    input  logic [DDR3_ADDR_W-1:0]       ddr3_buffer1_offset,
    output logic                         clear_buffer0,
    output logic                         clear_buffer1,
    output logic [DDR3_ADDR_W-1:0]       avm_address,
    output logic                         avm_read,
    output logic [$clog2(BURST_LEN):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid,
    input  logic [$clog2(FIFO_DEPTH):0]  fifo_used,
    output logic [DATA_W-1:0]            pix_data,
    output logic                         pix_valid,
    output logic                         pix_sof,
    output logic                         busy
);

    localparam int CNT_W = cnt_w(FRAME_WORDS);
    localparam int BC_W  = $clog2(BURST_LEN) + 1;

    state_t                   state;
    state_t                   state_next;
    logic                     sel;
    logic                     next_buf;
    logic                     idle_hold;
    logic                     pick;
    logic                     do_select;
    logic [DDR3_ADDR_W-1:0]   base;
    logic [1:0]               empty;
    logic                     accept;
    logic                     raise;
    logic [CNT_W-1:0]         issued_words;
    logic [CNT_W-1:0]         recv_words;
    logic                     credit_ok;
    logic                     last_burst;
    logic                     first_word;
    logic                     last_word;

    assign empty          = {ddr3_rd_buffer1_empty, ddr3_rd_buffer0_empty};
    assign accept         = avm_read && !avm_waitrequest;
    assign raise          = (state == ST_ISSUE) && !avm_read && credit_ok;
    assign avm_burstcount = BC_W'(BURST_LEN);

    ddr3_burst_credit #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_credit (
        .clk          (ddr3_clk),
        .rst          (ddr3_reset),
        .start        (do_select),
        .accept       (accept),
        .recv         (pix_valid),
        .fifo_used    (fifo_used),
        .issued_words (issued_words),
        .recv_words   (recv_words),
        .credit_ok    (credit_ok),
        .last_burst   (last_burst),
        .first_word   (first_word),
        .last_word    (last_word)
    );

    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_select  = 1'b0;
        pick       = next_buf;
        case (state)
            ST_IDLE: begin
                // idle_hold skips the first IDLE cycle so a stale empty flag is not acted on.
                if (!idle_hold) begin
                    if (!empty[next_buf]) begin
                        pick      = next_buf;
                        do_select = 1'b1;
                    end else if (!empty[~next_buf]) begin
                        pick      = ~next_buf;
                        do_select = 1'b1;
                    end
                end
                if (do_select)
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: if (accept && last_burst) state_next = ST_DRAIN;
            ST_DRAIN: if (pix_valid && last_word) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset) begin
            sel         <= 1'b0;
            next_buf    <= 1'b0;
            idle_hold   <= 1'b0;
            base        <= '0;
            busy        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
        end else begin
            idle_hold <= 1'b0;
            if (do_select) begin
                sel  <= pick;
                base <= pick ? ddr3_buffer1_offset : ddr3_buffer0_offset;
                busy <= 1'b1;
            end
            // A raised request is held unchanged until the slave accepts it.
            if (raise) begin
                avm_read    <= 1'b1;
                avm_address <= base + DDR3_ADDR_W'(issued_words);
            end else if (accept) begin
                avm_read <= 1'b0;
            end
            if (state == ST_CLEAR) begin
                next_buf  <= ~sel;
                busy      <= 1'b0;
                idle_hold <= 1'b1;
            end
        end
    end

    always_ff @(posedge ddr3_clk) begin
        if (ddr3_reset) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            pix_valid <= avm_readdatavalid && ((state == ST_ISSUE) || (state == ST_DRAIN));
            if (avm_readdatavalid)
                pix_data <= avm_readdata;
        end
    end

    assign pix_sof       = pix_valid && first_word;
    assign clear_buffer0 = (state == ST_CLEAR) && !sel;
    assign clear_buffer1 = (state == ST_CLEAR) && sel;

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Directed bench for ddr3_frame_reader with an Avalon burst slave and register-block flag model.
module tb_ddr3_frame_reader;
    import ddr3_frame_pkg::*;

    localparam int DATA_W      = 64;
    localparam int BURST_LEN   = 16;
    localparam int FRAME_WORDS = 64;
    localparam int FIFO_DEPTH  = 512;
    localparam int STALL_N     = 5;

    logic                         clk = 1'b0;
    logic                         ddr3_reset;
    logic                         ddr3_rd_buffer0_empty;
    logic                         ddr3_rd_buffer1_empty;
    logic [DDR3_ADDR_W-1:0]       off0;
    logic [DDR3_ADDR_W-1:0]       off1;
    logic                         clear_buffer0;
    logic                         clear_buffer1;
    logic [DDR3_ADDR_W-1:0]       avm_address;
    logic                         avm_read;
    logic [$clog2(BURST_LEN):0]   avm_burstcount;
    logic                         avm_waitrequest = 1'b0;
    logic [DATA_W-1:0]            avm_readdata = '0;
    logic                         avm_readdatavalid = 1'b0;
    logic [$clog2(FIFO_DEPTH):0]  fifo_used;
    logic [DATA_W-1:0]            pix_data;
    logic                         pix_valid;
    logic                         pix_sof;
    logic                         busy;

    // bench bookkeeping: main owns fill*, exp_bases, stall_target; the slave/monitor owns the rest
    int n_checks = 0;
    int n_errors = 0;
    int fill0 = 0, fill1 = 0, done0 = 0, done1 = 0;
    int total_words = 0, word_idx = 0, sof_cnt = 0, data_bad = 0;
    int clr0_cnt = 0, clr1_cnt = 0, clr_n = 0, clr_wide = 0;
    int burst_total = 0, stall_target = -1, stall_cnt = 0, stall_bad = 0;
    int clr_order [16];
    logic [DDR3_ADDR_W-1:0] acc_addr [64];
    logic [DDR3_ADDR_W-1:0] exp_bases [16];
    logic [DDR3_ADDR_W-1:0] rq [$];
    int bw, bb, bs, bd, bc0, bc1, bn;

    assign ddr3_rd_buffer0_empty = (fill0 == done0);
    assign ddr3_rd_buffer1_empty = (fill1 == done1);

    always #5 clk = ~clk;

    ddr3_frame_reader #(
        .DATA_W      (DATA_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .ddr3_clk              (clk),
        .ddr3_reset            (ddr3_reset),
        .ddr3_rd_buffer0_empty (ddr3_rd_buffer0_empty),
        .ddr3_rd_buffer1_empty (ddr3_rd_buffer1_empty),
        .ddr3_buffer0_offset   (off0),
        .ddr3_buffer1_offset   (off1),
        .clear_buffer0         (clear_buffer0),
        .clear_buffer1         (clear_buffer1),
        .avm_address           (avm_address),
        .avm_read              (avm_read),
        .avm_burstcount        (avm_burstcount),
        .avm_waitrequest       (avm_waitrequest),
        .avm_readdata          (avm_readdata),
        .avm_readdatavalid     (avm_readdatavalid),
        .fifo_used             (fifo_used),
        .pix_data              (pix_data),
        .pix_valid             (pix_valid),
        .pix_sof               (pix_sof),
        .busy                  (busy)
    );

    function automatic logic [DATA_W-1:0] dfun(input logic [DDR3_ADDR_W-1:0] a);
        return 64'hA5A5_0000_0000_0000 | {38'd0, a};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        bw = total_words; bb = burst_total; bs = sof_cnt; bd = data_bad;
        bc0 = clr0_cnt; bc1 = clr1_cnt; bn = clr_n;
    endtask

    task automatic wait_clr(input string tag, input int target, input int budget);
        int n = 0;
        while ((clr_n < target || busy) && n < budget) begin
            step(1);
            n++;
        end
        check_val(tag, 64'(n < budget), 64'd1);
    endtask

    // Avalon slave and output monitor, both acting on the falling edge.
    initial begin : slave_mon
        logic [DDR3_ADDR_W-1:0] a;
        logic [DDR3_ADDR_W-1:0] cur_base;
        logic [DDR3_ADDR_W-1:0] stall_addr;
        logic seen, prev_c0, prev_c1, pend0, pend1;
        cur_base = '0; stall_addr = '0;
        seen = 1'b0; prev_c0 = 1'b0; prev_c1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        forever begin
            @(negedge clk);
            if (pix_valid) begin
                if (pix_sof) begin
                    cur_base = exp_bases[sof_cnt % 16];
                    sof_cnt++;
                    word_idx = 0;
                    seen = 1'b1;
                end
                if (!seen || pix_data !== dfun(cur_base + DDR3_ADDR_W'(word_idx)))
                    data_bad++;
                word_idx++;
                total_words++;
            end
            if (clear_buffer0) begin clr0_cnt++; clr_order[clr_n % 16] = 0; clr_n++; end
            if (clear_buffer1) begin clr1_cnt++; clr_order[clr_n % 16] = 1; clr_n++; end
            if ((clear_buffer0 && prev_c0) || (clear_buffer1 && prev_c1) || (clear_buffer0 && clear_buffer1))
                clr_wide++;
            prev_c0 = clear_buffer0;
            prev_c1 = clear_buffer1;
            // register block raises the empty flag one cycle after the clear strobe
            if (pend0) done0++;
            if (pend1) done1++;
            pend0 = clear_buffer0;
            pend1 = clear_buffer1;

            if (ddr3_reset) begin
                rq.delete();
                avm_readdatavalid = 1'b0;
                avm_waitrequest = 1'b0;
            end else begin
                if (rq.size() > 0) begin
                    a = rq.pop_front();
                    avm_readdata = dfun(a);
                    avm_readdatavalid = 1'b1;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
                avm_waitrequest = 1'b0;
                if (avm_read) begin
                    if (burst_total == stall_target && stall_cnt < STALL_N) begin
                        if (stall_cnt == 0) stall_addr = avm_address;
                        else if (avm_address !== stall_addr) stall_bad++;
                        stall_cnt++;
                        avm_waitrequest = 1'b1;
                    end else begin
                        if (burst_total == stall_target && avm_address !== stall_addr) stall_bad++;
                        acc_addr[burst_total % 64] = avm_address;
                        burst_total++;
                        for (int i = 0; i < BURST_LEN; i++)
                            rq.push_back(avm_address + DDR3_ADDR_W'(i));
                    end
                end else if (burst_total == stall_target && stall_cnt > 0) begin
                    stall_bad++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int hi;
        int n;
        int bb2;
        ddr3_reset = 1'b1;
        off0 = 26'h0001000;
        off1 = 26'h0200000;
        fifo_used = '0;
        step(3);

        check_val("rst_avm_read", 64'(avm_read), 64'd0);
        check_val("rst_pix_valid", 64'(pix_valid), 64'd0);
        check_val("rst_pix_sof", 64'(pix_sof), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_clear", 64'({clear_buffer1, clear_buffer0}), 64'd0);
        check_val("rst_pix_data", pix_data, 64'd0);
        check_val("burstcount", 64'(avm_burstcount), 64'd16);
        ddr3_reset = 1'b0;
        step(2);

        // single buffer 0 frame
        snap();
        exp_bases[sof_cnt % 16] = 26'h0001000;
        fill0++;
        wait_clr("t1_done", bn + 1, 400);
        check_val("t1_bursts", 64'(burst_total - bb), 64'd4);
        for (int k = 0; k < 4; k++)
            check_val("t1_addr", 64'(acc_addr[(bb + k) % 64]), 64'(26'h0001000 + 16 * k));
        check_val("t1_words", 64'(total_words - bw), 64'd64);
        check_val("t1_data", 64'(data_bad - bd), 64'd0);
        check_val("t1_sof", 64'(sof_cnt - bs), 64'd1);
        check_val("t1_clr0", 64'(clr0_cnt - bc0), 64'd1);
        check_val("t1_clr1", 64'(clr1_cnt - bc1), 64'd0);
        check_val("t1_busy", 64'(busy), 64'd0);
        step(10);
        check_val("t1_no_reread", 64'(burst_total - bb), 64'd4);
        check_val("t1_words_after", 64'(total_words - bw), 64'd64);

        // both buffers pending at reset release
        ddr3_reset = 1'b1;
        fill0++;
        fill1++;
        step(2);
        snap();
        exp_bases[sof_cnt % 16] = 26'h0001000;
        exp_bases[(sof_cnt + 1) % 16] = 26'h0200000;
        ddr3_reset = 1'b0;
        wait_clr("t2_done", bn + 2, 800);
        check_val("t2_order0", 64'(clr_order[bn % 16]), 64'd0);
        check_val("t2_order1", 64'(clr_order[(bn + 1) % 16]), 64'd1);
        check_val("t2_bursts", 64'(burst_total - bb), 64'd8);
        check_val("t2_addr_b0", 64'(acc_addr[bb % 64]), 64'h0001000);
        check_val("t2_addr_b1", 64'(acc_addr[(bb + 4) % 64]), 64'h0200000);
        check_val("t2_words", 64'(total_words - bw), 64'd128);
        check_val("t2_data", 64'(data_bad - bd), 64'd0);
        check_val("t2_next_buf", 64'(dut.next_buf), 64'd0);

        // waitrequest stall on the second burst
        snap();
        exp_bases[sof_cnt % 16] = 26'h0001000;
        stall_target = burst_total + 1;
        fill0++;
        wait_clr("t3_done", bn + 1, 400);
        check_val("t3_stall_cycles", 64'(stall_cnt), 64'd5);
        check_val("t3_stall_stable", 64'(stall_bad), 64'd0);
        check_val("t3_bursts", 64'(burst_total - bb), 64'd4);
        check_val("t3_addr1", 64'(acc_addr[(bb + 1) % 64]), 64'h0001010);
        check_val("t3_words", 64'(total_words - bw), 64'd64);
        check_val("t3_data", 64'(data_bad - bd), 64'd0);

        // FIFO credit one word short
        snap();
        exp_bases[sof_cnt % 16] = 26'h0001000;
        fifo_used = 10'(FIFO_DEPTH - BURST_LEN + 1);
        fill0++;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (avm_read) hi++;
        end
        check_val("t4_no_read", 64'(hi), 64'd0);
        check_val("t4_busy", 64'(busy), 64'd1);
        fifo_used = '0;
        step(1);
        check_val("t4_read_now", 64'(avm_read), 64'd1);
        check_val("t4_addr", 64'(avm_address), 64'h0001000);
        wait_clr("t4_done", bn + 1, 400);
        check_val("t4_words", 64'(total_words - bw), 64'd64);
        check_val("t4_data", 64'(data_bad - bd), 64'd0);

        // address wrap at 2^26
        off0 = 26'h3FFFFF8;
        step(1);
        snap();
        exp_bases[sof_cnt % 16] = 26'h3FFFFF8;
        fill0++;
        wait_clr("t5_done", bn + 1, 400);
        check_val("t5_addr0", 64'(acc_addr[bb % 64]), 64'h3FFFFF8);
        check_val("t5_addr1", 64'(acc_addr[(bb + 1) % 64]), 64'h0000008);
        check_val("t5_words", 64'(total_words - bw), 64'd64);
        check_val("t5_data", 64'(data_bad - bd), 64'd0);
        check_val("t5_sof", 64'(sof_cnt - bs), 64'd1);

        // reset in the middle of a frame
        off0 = 26'h0001000;
        step(1);
        snap();
        exp_bases[sof_cnt % 16] = 26'h0001000;
        exp_bases[(sof_cnt + 1) % 16] = 26'h0001000;
        fill0++;
        n = 0;
        while (total_words - bw < 20 && n < 300) begin
            step(1);
            n++;
        end
        check_val("t6_reach20", 64'(n < 300), 64'd1);
        ddr3_reset = 1'b1;
        step(1);
        check_val("t6_rst_read", 64'(avm_read), 64'd0);
        check_val("t6_rst_valid", 64'(pix_valid), 64'd0);
        check_val("t6_rst_busy", 64'(busy), 64'd0);
        step(2);
        check_val("t6_no_clear", 64'(clr_n - bn), 64'd0);
        bb2 = burst_total;
        ddr3_reset = 1'b0;
        wait_clr("t6_done", bn + 1, 500);
        check_val("t6_readdr", 64'(acc_addr[bb2 % 64]), 64'h0001000);
        check_val("t6_sof", 64'(sof_cnt - bs), 64'd2);
        check_val("t6_full_frame", 64'(word_idx), 64'd64);
        check_val("t6_data", 64'(data_bad - bd), 64'd0);
        check_val("t6_clr0", 64'(clr0_cnt - bc0), 64'd1);
        check_val("clear_width", 64'(clr_wide), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
